// File: rtl/sm_imem_loader.sv
// sm_imem_loader: receives a length-prefixed little-endian byte stream and
// writes it word by word into instruction memory while holding the CPU in reset.
// Optional feature: define SM_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte after the last data word.
module sm_imem_loader #(
  parameter int SIZE = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        we,
  output logic [31:0] wa,
  output logic [31:0] wd,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
`ifdef SM_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } state_t;

  localparam logic [16:0] SIZE_W = 17'(SIZE);

  state_t      state;
  state_t      nstate;
  logic        hs;
  logic        go;
  logic [15:0] len_req;
  logic        len_bad;
  logic [15:0] len;
  logic [15:0] widx;
  logic [1:0]  bcnt;
  logic [23:0] asm_p0;
  logic        wlast;
`ifdef SM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign hs      = rx_valid & rx_ready;
  // Word count as it will be once the LEN1 byte is taken; only meaningful in LEN1.
  assign len_req = {rx_data, len[7:0]};
  assign len_bad = {1'b0, len_req} > SIZE_W;

  // Next-state and state-decoded outputs.
  always_comb begin
    nstate   = state;
    rx_ready = 1'b0;
    cpu_hold = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    go       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          go     = 1'b1;
          nstate = LEN0;
        end
      end
      LEN0: begin
        rx_ready = 1'b1;
        cpu_hold = 1'b1;
        if (hs) nstate = LEN1;
      end
      LEN1: begin
        rx_ready = 1'b1;
        cpu_hold = 1'b1;
        if (hs) begin
          if (len_bad)              nstate = ERR;
          else if (len_req == 16'd0) nstate = DONE;
          else                       nstate = DATA;
        end
      end
      DATA: begin
        // The cycle carrying the final write takes no byte, so nothing beyond
        // the last word is ever consumed as data.
        rx_ready = ~wlast;
        cpu_hold = 1'b1;
        if (wlast) begin
`ifdef SM_LOADER_CHECKSUM_EN
          nstate = CHK;
`else
          nstate = DONE;
`endif
        end
      end
`ifdef SM_LOADER_CHECKSUM_EN
      CHK: begin
        rx_ready = 1'b1;
        cpu_hold = 1'b1;
        if (hs) nstate = (rx_data == csum) ? DONE : ERR;
      end
`endif
      DONE: begin
        done = 1'b1;
        if (start) begin
          go     = 1'b1;
          nstate = LEN0;
        end
      end
      ERR: begin
        err = 1'b1;
        if (start) begin
          go     = 1'b1;
          nstate = LEN0;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  // State register, counters and the registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      we    <= 1'b0;
      wa    <= 32'd0;
      wd    <= 32'd0;
      bcnt  <= 2'd0;
      widx  <= 16'd0;
      wlast <= 1'b0;
`ifdef SM_LOADER_CHECKSUM_EN
      csum  <= 8'd0;
`endif
    end else begin
      state <= nstate;
      we    <= 1'b0;
      if (go) begin
        bcnt  <= 2'd0;
        widx  <= 16'd0;
        wlast <= 1'b0;
`ifdef SM_LOADER_CHECKSUM_EN
        csum  <= 8'd0;
`endif
      end else if (state == DATA) begin
        if (wlast) begin
          wlast <= 1'b0;
        end else if (hs) begin
          bcnt <= bcnt + 2'd1;
`ifdef SM_LOADER_CHECKSUM_EN
          csum <= csum ^ rx_data;
`endif
          if (bcnt == 2'd3) begin
            we    <= 1'b1;
            wa    <= {14'd0, widx, 2'b00};
            wd    <= {rx_data, asm_p0};
            widx  <= widx + 16'd1;
            wlast <= (widx == len - 16'd1);
          end
        end
      end
    end
  end

  // Byte capture: length bytes and the first three bytes of each word.
  always_ff @(posedge clk) begin
    if (hs) begin
      if (state == LEN0) len[7:0]  <= rx_data;
      if (state == LEN1) len[15:8] <= rx_data;
      if (state == DATA) asm_p0    <= {rx_data, asm_p0[23:8]};
    end
  end

endmodule

// File: tb/tb_sm_imem_loader.sv
// Testbench for sm_imem_loader: directed scenarios plus randomized loads checked
// against a byte-stream reference model. Define SM_LOADER_CHECKSUM_EN for both
// bench and design to exercise the checksum build.
module tb_sm_imem_loader;
  localparam int SIZE = 64;

  typedef logic [7:0]  bq_t[$];
  typedef logic [63:0] wq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        we;
  logic [31:0] wa;
  logic [31:0] wd;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int  total = 0;
  int  bad = 0;
  wq_t got;

  sm_imem_loader #(.SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .we(we), .wa(wa), .wd(wd), .cpu_hold(cpu_hold),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Record every write strobe as {address, data}.
  always @(negedge clk) if (we === 1'b1) got.push_back({wa, wd});

  // Reference: expected writes and outcome derived from the byte stream alone.
  function automatic void model(input bq_t s, output wq_t w, output bit ok);
    int n;
    logic [7:0] x;
    w = {};
    x = 8'd0;
    n = int'(s[0]) + 256 * int'(s[1]);
    ok = (n <= SIZE);
    if (!ok) return;
    for (int i = 0; i < n; i++) begin
      w.push_back({32'(4 * i), s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]});
      for (int j = 0; j < 4; j++) x = x ^ s[2+4*i+j];
    end
`ifdef SM_LOADER_CHECKSUM_EN
    if (n > 0) ok = (s[2+4*n] == x);
`endif
  endfunction

  task automatic send_byte(input logic [7:0] b, input int g, inout bit to);
    int cnt;
    repeat (g) begin @(posedge clk); #1; end
    rx_data  = b;
    rx_valid = 1'b1;
    cnt = 0;
    while (rx_ready !== 1'b1 && cnt < 50) begin @(posedge clk); #1; cnt++; end
    if (cnt >= 50) to = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_end(inout bit to);
    int cnt;
    cnt = 0;
    while (!(done === 1'b1 || err === 1'b1) && cnt < 20) begin @(negedge clk); cnt++; end
    if (cnt >= 20) to = 1'b1;
    @(negedge clk);
  endtask

  // gapmode 0: back-to-back, 1: rx_valid every other cycle, 2: random gaps.
  task automatic drive_load(input bq_t s, input int gapmode, output bit to);
    int g;
    to = 1'b0;
    got.delete();
    pulse_start();
    foreach (s[i]) begin
      g = (gapmode == 0) ? 0 : (gapmode == 1) ? 1 : int'($urandom_range(0, 3));
      if (!to) send_byte(s[i], g, to);
    end
    wait_end(to);
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({rx_ready, we, cpu_hold, done, err} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=00000", {rx_ready, we, cpu_hold, done, err});
    end
    total++;
    if ({wa, wd} !== 64'd0) begin
      bad++; $display("FAIL reset_addr_data got=%h want=0", {wa, wd});
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_two_words();
    bq_t s;
    bit to;
    s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'hB7, 8'h02, 8'h00, 8'h00};
`ifdef SM_LOADER_CHECKSUM_EN
    s.push_back(8'hB3);
`endif
    drive_load(s, 0, to);
    total++;
    if ({to, done, err, cpu_hold} !== 4'b0100) begin
      bad++; $display("FAIL two_words_status to/done/err/hold got=%b want=0100", {to, done, err, cpu_hold});
    end
    total++;
    if (got.size() !== 2) begin
      bad++; $display("FAIL two_words_count got=%0d want=2", got.size());
    end else begin
      total++;
      if (got[0] !== {32'd0, 32'h00100513}) begin
        bad++; $display("FAIL two_words_w0 got=%h want=%h", got[0], {32'd0, 32'h00100513});
      end
      total++;
      if (got[1] !== {32'd4, 32'h000002B7}) begin
        bad++; $display("FAIL two_words_w1 got=%h want=%h", got[1], {32'd4, 32'h000002B7});
      end
    end
  endtask

  task automatic test_len_too_big();
    bit to;
    drive_load('{8'h41, 8'h00}, 0, to);
    repeat (3) @(negedge clk);
    total++;
    if ({to, done, err, rx_ready, cpu_hold} !== 5'b00100) begin
      bad++; $display("FAIL too_big_status to/done/err/rdy/hold got=%b want=00100", {to, done, err, rx_ready, cpu_hold});
    end
    total++;
    if (got.size() !== 0) begin
      bad++; $display("FAIL too_big_writes got=%0d want=0", got.size());
    end
  endtask

  task automatic test_zero_len();
    bit to;
    drive_load('{8'h00, 8'h00}, 0, to);
    total++;
    if ({to, done, err, cpu_hold} !== 4'b0100 || got.size() !== 0) begin
      bad++; $display("FAIL zero_len to/done/err/hold=%b writes=%0d want 0100 and 0", {to, done, err, cpu_hold}, got.size());
    end
  endtask

  task automatic test_gaps();
    bq_t s;
    bit to;
    s = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00};
`ifdef SM_LOADER_CHECKSUM_EN
    s.push_back(8'h06);
`endif
    drive_load(s, 1, to);
    total++;
    if ({to, done, err} !== 3'b010 || got.size() !== 1) begin
      bad++; $display("FAIL gaps_status to/done/err=%b writes=%0d want 010 and 1", {to, done, err}, got.size());
    end else begin
      total++;
      if (got[0] !== {32'd0, 32'h00100513}) begin
        bad++; $display("FAIL gaps_w0 got=%h want=%h", got[0], {32'd0, 32'h00100513});
      end
    end
  endtask

  task automatic test_start_ignored();
    bit to;
    to = 1'b0;
    got.delete();
    pulse_start();
    send_byte(8'h01, 0, to); send_byte(8'h00, 0, to);
    send_byte(8'h13, 0, to); send_byte(8'h05, 0, to);
    pulse_start();
    total++;
    if (cpu_hold !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL start_ignored_busy hold=%b done=%b want 1 0", cpu_hold, done);
    end
    send_byte(8'h10, 0, to); send_byte(8'h00, 0, to);
`ifdef SM_LOADER_CHECKSUM_EN
    send_byte(8'h06, 0, to);
`endif
    wait_end(to);
    total++;
    if ({to, done, err} !== 3'b010 || got.size() !== 1) begin
      bad++; $display("FAIL start_ignored_end to/done/err=%b writes=%0d want 010 and 1", {to, done, err}, got.size());
    end else begin
      total++;
      if (got[0] !== {32'd0, 32'h00100513}) begin
        bad++; $display("FAIL start_ignored_w0 got=%h want=%h", got[0], {32'd0, 32'h00100513});
      end
    end
  endtask

  task automatic test_reset_midload();
    bit to;
    bq_t s;
    to = 1'b0;
    got.delete();
    pulse_start();
    send_byte(8'h01, 0, to); send_byte(8'h00, 0, to);
    send_byte(8'h13, 0, to); send_byte(8'h05, 0, to);
    @(negedge clk); rst = 1'b1; #1;
    total++;
    if ({rx_ready, we, cpu_hold, done, err} !== 5'b0 || {wa, wd} !== 64'd0) begin
      bad++; $display("FAIL midload_reset ctrl=%b wa_wd=%h want 0", {rx_ready, we, cpu_hold, done, err}, {wa, wd});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    total++;
    if (got.size() !== 0) begin
      bad++; $display("FAIL midload_no_write got=%0d want=0", got.size());
    end
    s = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef SM_LOADER_CHECKSUM_EN
    s.push_back(8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE);
`endif
    drive_load(s, 0, to);
    total++;
    if ({to, done, err} !== 3'b010 || got.size() !== 1) begin
      bad++; $display("FAIL midload_reload to/done/err=%b writes=%0d want 010 and 1", {to, done, err}, got.size());
    end else begin
      total++;
      if (got[0] !== {32'd0, 32'hDEADBEEF}) begin
        bad++; $display("FAIL midload_reload_w0 got=%h want=%h", got[0], {32'd0, 32'hDEADBEEF});
      end
    end
  endtask

`ifdef SM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bit to;
    drive_load('{8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h06}, 0, to);
    total++;
    if ({to, done, err} !== 3'b010 || got.size() !== 1) begin
      bad++; $display("FAIL csum_good to/done/err=%b writes=%0d want 010 and 1", {to, done, err}, got.size());
    end
    drive_load('{8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h07}, 0, to);
    total++;
    if ({to, done, err} !== 3'b001 || got.size() !== 1) begin
      bad++; $display("FAIL csum_bad to/done/err=%b writes=%0d want 001 and 1", {to, done, err}, got.size());
    end
  endtask
`endif

  // Randomized loads, including full-depth and one-over-depth lengths.
  task automatic test_random(input int iters);
    bq_t s;
    wq_t w;
    bit ok;
    bit to;
    int n;
    int r;
    logic [7:0] x;
    for (int it = 0; it < iters; it++) begin
      r = int'($urandom_range(0, 9));
      if (it == 0)      n = SIZE;
      else if (r == 0)  n = 0;
      else if (r == 1)  n = SIZE;
      else if (r == 2)  n = SIZE + 1;
      else if (r == 3)  n = int'($urandom_range(SIZE + 2, 700));
      else              n = int'($urandom_range(1, 6));
      s = {};
      s.push_back(8'(n));
      s.push_back(8'(n >> 8));
      x = 8'd0;
      if (n <= SIZE) begin
        for (int i = 0; i < 4 * n; i++) begin
          s.push_back(8'($urandom));
          x = x ^ s[s.size()-1];
        end
`ifdef SM_LOADER_CHECKSUM_EN
        if (n > 0) s.push_back(($urandom_range(0, 1) == 0) ? x : (x ^ 8'(1 + $urandom_range(0, 254))));
`endif
      end
      model(s, w, ok);
      drive_load(s, 2, to);
      total++;
      if ({to, done, err} !== {1'b0, ok, ~ok}) begin
        bad++; $display("FAIL rand%0d_status n=%0d to/done/err=%b want=%b", it, n, {to, done, err}, {1'b0, ok, ~ok});
      end
      total++;
      if (got.size() !== w.size()) begin
        bad++; $display("FAIL rand%0d_count got=%0d want=%0d", it, got.size(), w.size());
      end else begin
        for (int i = 0; i < w.size(); i++) begin
          total++;
          if (got[i] !== w[i]) begin
            bad++; $display("FAIL rand%0d_w%0d got=%h want=%h", it, i, got[i], w[i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_len_too_big();
    test_zero_len();
    test_gaps();
    test_start_ignored();
    test_reset_midload();
`ifdef SM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_random(12);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sm_imem_loader.md
SM_IMEM_LOADER -- requirements
Module: sm_imem_loader

Interface
REQ-001 SHALL have parameter SIZE, default 64, giving the instruction memory depth in 32-bit words.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: single-cycle request to begin a load.
REQ-005 SHALL have port rx_data, input, 8 bits: incoming stream byte.
REQ-006 SHALL have port rx_valid, input, 1 bit: rx_data is valid.
REQ-007 SHALL have port rx_ready, output, 1 bit: loader accepts a byte; a byte transfers on a cycle with rx_valid and rx_ready both high.
REQ-008 SHALL have port we, output, 1 bit: instruction memory write strobe.
REQ-009 SHALL have port wa, output, 32 bits: byte write address, always word-aligned (memory indexes by wa >> 2).
REQ-010 SHALL have port wd, output, 32 bits: write data.
REQ-011 SHALL have port cpu_hold, output, 1 bit: holds the CPU in reset while a load is in progress.
REQ-012 SHALL have port done, output, 1 bit: the load completed successfully.
REQ-013 SHALL have port err, output, 1 bit: the load was aborted.

Function
REQ-014 SHALL implement the states IDLE, LEN0, LEN1, DATA, CHK, DONE and ERR.
REQ-015 SHALL move IDLE->LEN0 on start; start SHALL be ignored in LEN0, LEN1, DATA and CHK.
REQ-016 SHALL also accept start in DONE and ERR, clearing done and err and restarting at LEN0.
REQ-017 SHALL accept two length bytes in LEN0 and LEN1, forming the 16-bit word count N little-endian.
REQ-018 SHALL, at the LEN1 handshake, go to ERR if N > SIZE, to DONE if N = 0 (no writes), and to DATA otherwise.
REQ-019 SHALL, in DATA, assemble 4 accepted bytes little-endian into one word (the first byte becomes wd[7:0]).
REQ-020 SHALL assert we for exactly one cycle, in the cycle after the 4th byte handshake, with wd = the assembled word and wa = 4*k for word index k, where k runs 0..N-1.
REQ-021 SHALL leave DATA after the write of word N-1, going to CHK if the checksum is enabled and to DONE otherwise.
REQ-022 SHALL drive rx_ready high only in LEN0, LEN1, DATA and CHK, and SHALL tolerate rx_valid gaps of any length without losing bytes.
REQ-023 SHALL drive cpu_hold high in LEN0, LEN1, DATA and CHK, and low in IDLE, DONE and ERR.
REQ-024 SHALL hold done high only in DONE and err high only in ERR.
REQ-025 SHALL keep wa and wd stable while we is low and SHALL never issue a write at an address of SIZE*4 or above.

Reset
REQ-026 SHALL, on rst, enter IDLE immediately with rx_ready=0, we=0, wa=0, wd=0, cpu_hold=0, done=0, err=0, and the byte and word counters cleared.
REQ-027 SHALL, on rst during a load, abandon the load; words already written remain in memory and no further write occurs.

Configuration
REQ-028 SHALL, with SM_LOADER_CHECKSUM_EN defined, enter CHK after the last word and accept one byte there.
REQ-029 SHALL, in CHK, go to DONE if that byte equals the XOR of all data bytes, and to ERR otherwise.
REQ-030 SHALL, without SM_LOADER_CHECKSUM_EN, omit the CHK state, the running XOR and the checksum byte entirely.

Verification
REQ-031 SHALL verify: start; bytes 02 00 13 05 10 00 B7 02 00 00 -> writes wa=0 wd=00100513, then wa=4 wd=000002B7; done=1, cpu_hold=0.
REQ-032 SHALL verify: start; length bytes 41 00 with SIZE=64 -> err=1, no we pulse, rx_ready=0.
REQ-033 SHALL verify: start; length bytes 00 00 -> done=1 with no writes.
REQ-034 SHALL verify: the one-word load with rx_valid toggled every other cycle -> same single write, wd=00100513.
REQ-035 SHALL verify: rst asserted after 2 of the 4 data bytes -> all outputs return to reset values at once; a subsequent full load succeeds.
REQ-036 SHALL verify, with SM_LOADER_CHECKSUM_EN: one word 00100513 with checksum 06 -> done=1; with checksum 07 -> err=1 after the write.
